// File: rtl/sched_pkg.sv
// Shared types, widths and default timing for the class-period scheduler.
package sched_pkg;

  localparam int unsigned TIME_W   = 11;
  localparam int unsigned PERIOD_W = 4;
  localparam int unsigned MINS_W   = 7;

  localparam int unsigned START_MIN_DEF   = 540;
  localparam int unsigned CLASS_LEN_DEF   = 50;
  localparam int unsigned BREAK_LEN_DEF   = 10;
  localparam int unsigned LUNCH_LEN_DEF   = 60;
  localparam int unsigned NUM_PERIODS_DEF = 8;
  localparam int unsigned LUNCH_AFTER_DEF = 4;

  typedef enum logic [2:0] {
    ST_PRE   = 3'd0,
    ST_CLASS = 3'd1,
    ST_BREAK = 3'd2,
    ST_LUNCH = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic                in_class;
    logic                in_break;
    logic                in_lunch;
    logic [MINS_W-1:0]   mins_left;
    logic                period_start;
    logic                day_done;
  } sched_out_t;

  localparam sched_out_t SCHED_OUT_IDLE = '0;

  // Segment flags {in_class, in_break, in_lunch} implied by a state.
  function automatic logic [2:0] seg_flags(sched_state_e s);
    logic [2:0] f;
    f = 3'b000;
    case (s)
      ST_CLASS: f = 3'b100;
      ST_BREAK: f = 3'b010;
      ST_LUNCH: f = 3'b001;
      default:  f = 3'b000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/sched_tick_det.sv
// Detects minute ticks, day wrap and day-reset rising edges from the upstream day timer.
module sched_tick_det
  import sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TIME_W-1:0] time_i,
  input  logic              day_rst_i,
  output logic              tick_c,
  output logic              wrap_c,
  output logic              day_rise_c
);

  logic [TIME_W-1:0] time_q;
  logic              day_q;

  // History tracks live inputs during reset so release never looks like an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= time_i;
      day_q  <= day_rst_i;
    end else begin
      time_q <= time_i;
      day_q  <= day_rst_i;
    end
  end

  assign tick_c     = (time_i != time_q);
  assign wrap_c     = tick_c && (time_i < time_q);
  assign day_rise_c = day_rst_i && !day_q;

endmodule

// File: rtl/period_scheduler.sv
// School-day period scheduler: walks class, break and lunch segments on minute ticks.
module period_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned START_MIN   = START_MIN_DEF,
  parameter int unsigned CLASS_LEN   = CLASS_LEN_DEF,
  parameter int unsigned BREAK_LEN   = BREAK_LEN_DEF,
  parameter int unsigned LUNCH_LEN   = LUNCH_LEN_DEF,
  parameter int unsigned NUM_PERIODS = NUM_PERIODS_DEF,
  parameter int unsigned LUNCH_AFTER = LUNCH_AFTER_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TIME_W-1:0]   time_in,
  input  logic                day_rst,
  output logic [PERIOD_W-1:0] period,
  output logic                in_class,
  output logic                in_break,
  output logic                in_lunch,
  output logic [MINS_W-1:0]   mins_left,
  output logic                period_start,
  output logic                day_done
);

  logic         tick_c;
  logic         wrap_c;
  logic         day_rise_c;
  sched_state_e state_q, state_d;
  sched_out_t   out_q, out_d;

  sched_tick_det u_tick_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_i     (time_in),
    .day_rst_i  (day_rst),
    .tick_c     (tick_c),
    .wrap_c     (wrap_c),
    .day_rise_c (day_rise_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PRE;
      out_q   <= SCHED_OUT_IDLE;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Day boundaries pre-empt everything; otherwise only a tick moves the schedule.
  always_comb begin
    state_d            = state_q;
    out_d              = out_q;
    out_d.period_start = 1'b0;
    out_d.day_done     = 1'b0;

    if (day_rise_c || wrap_c) begin
      state_d         = ST_PRE;
      out_d.period    = '0;
      out_d.mins_left = '0;
    end else if (tick_c) begin
      case (state_q)
        ST_PRE: begin
          if (time_in == TIME_W'(START_MIN)) begin
            state_d            = ST_CLASS;
            out_d.period       = PERIOD_W'(1);
            out_d.mins_left    = MINS_W'(CLASS_LEN);
            out_d.period_start = 1'b1;
          end
        end
        ST_CLASS: begin
          if (out_q.mins_left > MINS_W'(1)) begin
            out_d.mins_left = out_q.mins_left - MINS_W'(1);
          end else if (out_q.period == PERIOD_W'(NUM_PERIODS)) begin
            state_d         = ST_DONE;
            out_d.period    = '0;
            out_d.mins_left = '0;
            out_d.day_done  = 1'b1;
          end else if (out_q.period == PERIOD_W'(LUNCH_AFTER)) begin
            state_d         = ST_LUNCH;
            out_d.mins_left = MINS_W'(LUNCH_LEN);
          end else begin
            state_d         = ST_BREAK;
            out_d.mins_left = MINS_W'(BREAK_LEN);
          end
        end
        ST_BREAK, ST_LUNCH: begin
          if (out_q.mins_left > MINS_W'(1)) begin
            out_d.mins_left = out_q.mins_left - MINS_W'(1);
          end else begin
            state_d            = ST_CLASS;
            out_d.period       = out_q.period + PERIOD_W'(1);
            out_d.mins_left    = MINS_W'(CLASS_LEN);
            out_d.period_start = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d         = ST_PRE;
          out_d.period    = '0;
          out_d.mins_left = '0;
        end
      endcase
    end

    {out_d.in_class, out_d.in_break, out_d.in_lunch} = seg_flags(state_d);
  end

  assign period       = out_q.period;
  assign in_class     = out_q.in_class;
  assign in_break     = out_q.in_break;
  assign in_lunch     = out_q.in_lunch;
  assign mins_left    = out_q.mins_left;
  assign period_start = out_q.period_start;
  assign day_done     = out_q.day_done;

endmodule

// File: tb/tb_period_scheduler.sv
// Scoreboard bench for period_scheduler against an elapsed-minutes schedule model.
module tb_period_scheduler;

  localparam int START = 540;
  localparam int CLEN  = 50;
  localparam int BLEN  = 10;
  localparam int LLEN  = 60;
  localparam int NP    = 8;
  localparam int LA    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] time_in = 11'd539;
  logic        day_rst = 1'b0;
  logic [3:0]  period;
  logic        in_class, in_break, in_lunch;
  logic [6:0]  mins_left;
  logic        period_start, day_done;
  logic [15:0] act_w;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  // Model state: mode 0 = before school, 1 = running, 2 = day finished.
  int mode   = 0;
  int el     = 0;
  int prev_t = 539;
  bit prev_d = 1'b0;
  int total;

  period_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .time_in      (time_in),
    .day_rst      (day_rst),
    .period       (period),
    .in_class     (in_class),
    .in_break     (in_break),
    .in_lunch     (in_lunch),
    .mins_left    (mins_left),
    .period_start (period_start),
    .day_done     (day_done)
  );

  always #5 clk = ~clk;

  assign act_w = {period, in_class, in_break, in_lunch, mins_left, period_start, day_done};

  // Segment k of the day: even k are classes, odd k are the gaps after class k/2+1.
  function automatic int seg_len(int k);
    if (k % 2 == 0) return CLEN;
    if (k / 2 + 1 == LA) return LLEN;
    return BLEN;
  endfunction

  function automatic int day_len();
    int s = 0;
    for (int k = 0; k < 2 * NP - 1; k++) s += seg_len(k);
    return s;
  endfunction

  function automatic bit class_start(int e);
    int st = 0;
    for (int k = 0; k < 2 * NP - 1; k++) begin
      if (k % 2 == 0 && k > 0 && st == e) return 1'b1;
      st += seg_len(k);
    end
    return 1'b0;
  endfunction

  function automatic logic [15:0] compose(int md, int e, bit ps, bit dd);
    logic [3:0] p;
    logic       c, b, l;
    logic [6:0] ml;
    int         st;
    int         len;
    p = 4'd0; c = 1'b0; b = 1'b0; l = 1'b0; ml = 7'd0; st = 0;
    if (md == 1) begin
      for (int k = 0; k < 2 * NP - 1; k++) begin
        len = seg_len(k);
        if (e >= st && e < st + len) begin
          p  = 4'(k / 2 + 1);
          c  = (k % 2 == 0);
          l  = (k % 2 == 1) && (k / 2 + 1 == LA);
          b  = (k % 2 == 1) && !(k / 2 + 1 == LA);
          ml = 7'(st + len - e);
        end
        st += len;
      end
    end
    return {p, c, b, l, ml, ps, dd};
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push the model's post-edge expectation.
  task automatic step(input int t, input bit d, input bit r);
    bit tick, wrap, rise, ps, dd;
    @(negedge clk);
    time_in = 11'(t);
    day_rst = d;
    rst_n   = r;
    ps = 1'b0;
    dd = 1'b0;
    if (!r) begin
      mode = 0;
      el   = 0;
    end else begin
      tick = (t != prev_t);
      wrap = tick && (t < prev_t);
      rise = d && !prev_d;
      if (rise || wrap) begin
        mode = 0;
      end else if (tick) begin
        if (mode == 0) begin
          if (t == START) begin
            mode = 1; el = 0; ps = 1'b1;
          end
        end else if (mode == 1) begin
          el++;
          if (el == total) begin
            mode = 2; dd = 1'b1;
          end else if (class_start(el)) begin
            ps = 1'b1;
          end
        end
      end
    end
    prev_t = t;
    prev_d = d;
    exp_q.push_back(compose(mode, el, ps, dd));
  endtask

  // Monitor: compares every registered output word after each rising edge.
  initial begin
    logic [15:0] ex;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        check(act_w == ex, "outputs", int'(act_w), int'(ex));
      end
    end
  end

  initial begin
    int cur;
    int r;
    bit d;
    total = day_len();

    for (int i = 0; i < 3; i++) step(539, 1'b0, 1'b0);
    step(539, 1'b0, 1'b1);
    step(539, 1'b0, 1'b1);

    for (int t = 540; t <= 1070; t++) begin
      step(t, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) step(t, 1'b0, 1'b1);
    end
    step(1439, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);

    for (int t = 530; t <= 545; t++) step(t, 1'b0, 1'b1);
    repeat (20) step(545, 1'b0, 1'b1);
    step(546, 1'b1, 1'b1);
    step(547, 1'b0, 1'b1);

    step(0, 1'b0, 1'b1);
    for (int t = 539; t <= 560; t++) step(t, 1'b0, 1'b1);
    step(560, 1'b0, 1'b0);
    #1;
    check(act_w == 16'h0, "async_reset_abort", int'(act_w), 0);
    step(560, 1'b0, 1'b0);
    step(560, 1'b0, 1'b1);
    for (int t = 561; t <= 600; t++) step(t, 1'b0, 1'b1);

    cur = 600;
    d   = 1'b0;
    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        step(cur, d, 1'b1);
      end else if (r < 90) begin
        cur = (cur + 1) % 1440;
        step(cur, d, 1'b1);
      end else if (r < 94) begin
        cur = int'($urandom_range(0, 1439));
        step(cur, d, 1'b1);
      end else if (r < 98) begin
        d = ~d;
        step(cur, d, 1'b1);
      end else begin
        step(cur, d, 1'b0);
      end
    end

    repeat (3) step(cur, d, 1'b1);
    @(posedge clk);
    #5;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
